// File: rtl/add_sub_pkg.sv
// Shared types and sizing helpers for the serial add/sub unit.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int num_digits(int w, int d);
    return w / d;
  endfunction

  function automatic int cnt_width(int w, int d);
    int n;
    n = w / d;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sub_unit_digit_adder.sv
// One-slice ripple adder, reused every cycle by serial_add_sub_unit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [DIGIT:0] c;

  always_comb begin
    c = '0;
    sum_o = '0;
    c[0] = cin_i;
    for (int i = 0; i < DIGIT; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[DIGIT];
  assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub_unit.sv
// Digit-serial two's-complement add/sub with valid/ready handshakes.
// Optional clamp on overflow: define ADD_SUB_SAT_EN.
module serial_add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             v,
  output logic             zero,
  output logic             neg
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
    $error("serial_add_sub_unit: DIGIT must divide WIDTH");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             v_q;
  logic             zero_q;
  logic             neg_q;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] s_fin;
  logic             v_raw;
  logic             accept;
  logic             last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .cin_i  (c_q),
    .sum_o  (dsum),
    .cout_o (dcout),
    .cmsb_o (dcmsb)
  );

  // a_q doubles as the result shift register: sum slices fill from the top
  if (DIGIT == WIDTH) begin : g_one
    assign res_nxt = dsum;
  end else begin : g_multi
    assign res_nxt = {dsum, a_q[WIDTH-1:DIGIT]};
  end

  assign v_raw = dcmsb ^ dcout;

  always_comb begin
    s_fin = res_nxt;
`ifdef ADD_SUB_SAT_EN
    if (v_raw) begin
      s_fin = res_nxt[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                               : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  assign in_ready = (state_q == IDLE) ||
                    (state_q == OUT && out_ready);
  assign accept = in_valid && in_ready;
  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      v_q     <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b ^ {WIDTH{op_sub}};
      c_q     <= op_sub;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          a_q   <= res_nxt;
          b_q   <= b_q >> DIGIT;
          c_q   <= dcout;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            cnt_q   <= '0;
            state_q <= OUT;
            s_q     <= s_fin;
            carry_q <= dcout;
            v_q     <= v_raw;
            zero_q  <= (s_fin == '0);
            neg_q   <= s_fin[WIDTH-1];
          end
        end
        OUT: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == OUT);
  assign s     = s_q;
  assign carry = carry_q;
  assign v     = v_q;
  assign zero  = zero_q;
  assign neg   = neg_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed bench for serial_add_sub_unit, WIDTH=8 DIGIT=2.
module tb_serial_add_sub_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         carry;
  logic         v;
  logic         zero;
  logic         neg;

  int checks = 0;
  int errors = 0;

  serial_add_sub_unit #(.WIDTH(8), .DIGIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .carry     (carry),
    .v         (v),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pack_out();
    return {s, carry, v, zero, neg};
  endfunction

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic start_op(input logic [7:0] ai, input logic [7:0] bi,
                          input logic sub);
    a = ai; b = bi; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [11:0] held;

    vecs[0] = '{8'h64, 8'h1B, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADD_SUB_SAT_EN
    vecs[1] = '{8'h64, 8'h1C, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    vecs[1] = '{8'h64, 8'h1C, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    vecs[2] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {20'd0, pack_out()}, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_result(lat);
      check($sformatf("latency_%0d", i), lat, 32'd4);
      check($sformatf("result_%0d", i), {20'd0, pack_out()},
            {20'd0, vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n});
      consume();
      check($sformatf("idle_%0d", i), {30'd0, out_valid, in_ready}, 32'd1);
    end

    // backpressure: result held, new request stalls, then back-to-back
    start_op(8'h64, 8'h1B, 1'b0);
    wait_result(lat);
    held = pack_out();
    check("bp_first", {20'd0, held}, {20'd0, 8'h7F, 4'b0000});
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 8'(8'h11 * (k + 1)); b = 8'(8'h22 + k); op_sub = k[0];
      #1;
      check($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_%0d", k), {19'd0, out_valid, pack_out()},
            {19'd0, 1'b1, held});
    end
    a = 8'h03; b = 8'h05; op_sub = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; a = 8'hAA; b = 8'h55;
    check("b2b_run", {31'd0, out_valid}, 32'd0);
    wait_result(lat);
    check("b2b_latency", lat, 32'd4);
    check("b2b_result", {20'd0, pack_out()}, {20'd0, 8'hFE, 4'b0001});

    // reset during RUN abandons the operation
    start_op(8'h64, 8'h1C, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {20'd0, pack_out()}, 32'd0);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    start_op(8'h05, 8'h05, 1'b1);
    wait_result(lat);
    check("post_rst_latency", lat, 32'd4);
    check("post_rst_result", {20'd0, pack_out()}, {20'd0, 8'h00, 4'b1010});
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
